led_pwm_bank: RTL and testbench

Parametrised multi-channel PWM LED driver for the board top level, replacing the single PWM line OR'd onto every LED. Each channel has its own duty level and mode (off / PWM / on / breathe), a shared prescaler sets the PWM rate, and the software LED bits are OR'd in per channel. It sits between the SoC's LED/PWM peripheral outputs and the board `leds` pins, in the SoC clock domain.

---
 rtl/led_pwm_pkg.sv | 13 +
 rtl/led_pwm_channel.sv | 79 +++++++
 rtl/led_pwm_bank.sv | 66 ++++++
 tb/tb_led_pwm_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types for the multi-channel LED PWM driver: channel mode encoding.
package led_pwm_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_ON      = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, period-aligned update, breathe stepper
// and duty compare against the shared PWM counter.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int RES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  led_mode_e      wr_mode,
  input  logic [RES-1:0] wr_duty,
  input  logic           boundary,
  input  logic [RES-1:0] pwm_cnt,
  output logic           pwm_on
);

  localparam logic [RES-1:0] DUTY_MAX = '1;
  localparam logic [RES-1:0] DUTY_ONE = RES'(1);

  led_mode_e      shadow_mode, act_mode;
  logic [RES-1:0] shadow_duty, act_duty;
  logic           pending;
  logic           dir;

  logic           step_up;
  logic [RES-1:0] next_duty;

  // Reverse early if a breathe level was loaded at an extreme so the duty never wraps.
  assign step_up   = dir ? (act_duty == '0) : (act_duty != DUTY_MAX);
  assign next_duty = step_up ? act_duty + DUTY_ONE : act_duty - DUTY_ONE;

  // NOTE: all state updates use <= so every register sees pre-edge values,
  // which is what lets a boundary apply the old shadow while a write loads the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mode <= MODE_OFF;
      shadow_duty <= '0;
      pending     <= 1'b0;
      act_mode    <= MODE_OFF;
      act_duty    <= '0;
      dir         <= 1'b0;
    end else begin
      if (boundary) begin
        if (pending) begin
          act_mode <= shadow_mode;
          act_duty <= shadow_duty;
          dir      <= 1'b0;
          pending  <= 1'b0;
        end else if (act_mode == MODE_BREATHE) begin
          act_duty <= next_duty;
          if (next_duty == DUTY_MAX)  dir <= 1'b1;
          else if (next_duty == '0)   dir <= 1'b0;
          else                        dir <= ~step_up;
        end
      end
      // Placed after the boundary update so a coincident write re-arms pending.
      if (load) begin
        shadow_mode <= wr_mode;
        shadow_duty <= wr_duty;
        pending     <= 1'b1;
      end
    end
  end

  // NOTE: pwm_on gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pwm_on = 1'b0;
    unique case (act_mode)
      MODE_OFF:     pwm_on = 1'b0;
      MODE_ON:      pwm_on = 1'b1;
      MODE_PWM,
      MODE_BREATHE: pwm_on = (pwm_cnt < act_duty);
      default:      pwm_on = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel PWM LED driver: shared prescaler and period counter, per-channel
// config, software LED bits OR'd into a registered output.
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter  int CHANNELS   = 8,
  parameter  int RES        = 8,
  parameter  int PRESCALE_W = 16,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [MODE_W-1:0]     wr_mode,
  input  logic [RES-1:0]        wr_duty,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CHANNELS-1:0]   base_leds,
  output logic [CHANNELS-1:0]   leds,
  output logic                  period_tick
);

  // Counter tops out at 2^RES-2 so duty 2^RES-1 stays on for the whole period.
  localparam logic [RES-1:0] CNT_MAX = RES'((1 << RES) - 2);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [RES-1:0]        pwm_cnt;
  logic                  tick;
  logic                  boundary;
  logic                  sel_valid;
  logic [CHANNELS-1:0]   pwm_on;

  // >= rather than == so lowering prescale mid-count ticks on the next cycle.
  assign tick      = (pre_cnt >= prescale);
  assign boundary  = tick && (pwm_cnt == CNT_MAX);
  assign sel_valid = (int'(wr_sel) < CHANNELS);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      leds        <= '0;
      period_tick <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
      if (tick)
        pwm_cnt   <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + RES'(1);
      leds        <= base_leds | pwm_on;
      period_tick <= boundary;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_pwm_channel #(.RES(RES)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_en && sel_valid && (int'(wr_sel) == i)),
      .wr_mode  (led_mode_e'(wr_mode)),
      .wr_duty  (wr_duty),
      .boundary (boundary),
      .pwm_cnt  (pwm_cnt),
      .pwm_on   (pwm_on[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench: an 8-bit/8-channel instance for duty, extremes and deferred
// updates; a 4-bit/7-channel instance for prescale changes, reset and breathe.
module tb_led_pwm_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 8 channels, RES 8
  logic        rst8, wr_en8, pt8;
  logic [2:0]  wr_sel8;
  logic [1:0]  wr_mode8;
  logic [7:0]  wr_duty8, base8, leds8;
  logic [15:0] prescale8;

  // 7 channels (select 7 is out of range), RES 4
  logic        rst4, wr_en4, pt4;
  logic [2:0]  wr_sel4;
  logic [1:0]  wr_mode4;
  logic [3:0]  wr_duty4;
  logic [6:0]  base4, leds4;
  logic [15:0] prescale4;

  led_pwm_bank #(.CHANNELS(8), .RES(8), .PRESCALE_W(16)) dut8 (
    .clk(clk), .rst(rst8), .wr_en(wr_en8), .wr_sel(wr_sel8), .wr_mode(wr_mode8),
    .wr_duty(wr_duty8), .prescale(prescale8), .base_leds(base8),
    .leds(leds8), .period_tick(pt8)
  );

  led_pwm_bank #(.CHANNELS(7), .RES(4), .PRESCALE_W(16)) dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_sel(wr_sel4), .wr_mode(wr_mode4),
    .wr_duty(wr_duty4), .prescale(prescale4), .base_leds(base4),
    .leds(leds4), .period_tick(pt4)
  );

  int checks   = 0;
  int failures = 0;

  int on_cnt [8];
  int pt_cnt;
  bit last_pt;

  // Breathe duty per period starting at 13 with RES=4 (triangle between 0 and 15).
  int exp_duty [20] = '{13, 14, 15, 14, 13, 12, 11, 10, 9, 8,
                        7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr8(input int sel, input int mode, input int duty);
    wr_en8 = 1'b1; wr_sel8 = 3'(sel); wr_mode8 = 2'(mode); wr_duty8 = 8'(duty);
    @(negedge clk);
    wr_en8 = 1'b0;
  endtask

  task automatic wr4(input int sel, input int mode, input int duty);
    wr_en4 = 1'b1; wr_sel4 = 3'(sel); wr_mode4 = 2'(mode); wr_duty4 = 4'(duty);
    @(negedge clk);
    wr_en4 = 1'b0;
  endtask

  // Advance negedge by negedge until period_tick is seen; n = cycles waited.
  task automatic wait_pt(input bit use4, input int limit, output int n);
    logic pt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pt = use4 ? pt4 : pt8;
    end while (!pt && n < limit);
    if (!pt) check("period_tick_timeout", pt, 1);
  endtask

  // Count high samples per LED over len cycles, starting from a period_tick sample.
  task automatic measure(input bit use4, input int len);
    logic [7:0] v;
    logic       pt;
    for (int b = 0; b < 8; b++) on_cnt[b] = 0;
    pt_cnt = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      v  = use4 ? {1'b0, leds4} : leds8;
      pt = use4 ? pt4 : pt8;
      for (int b = 0; b < 8; b++) on_cnt[b] += int'(v[b]);
      pt_cnt += int'(pt);
      last_pt = pt;
    end
  endtask

  initial begin
    int n;
    int others;
    rst8 = 1'b1; wr_en8 = 1'b0; wr_sel8 = '0; wr_mode8 = '0; wr_duty8 = '0;
    base8 = 8'hA5; prescale8 = 16'd0;
    rst4 = 1'b1; wr_en4 = 1'b0; wr_sel4 = '0; wr_mode4 = '0; wr_duty4 = '0;
    base4 = '0; prescale4 = 16'd5;

    // Reset held for three cycles with base bits present
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_leds", leds8, 0);
      check("reset_period_tick", pt8, 0);
    end
    rst8 = 1'b0;
    @(negedge clk);
    check("base_after_reset", leds8, 8'hA5);
    check("no_tick_after_reset", pt8, 0);
    wait_pt(0, 400, n);
    check("first_boundary_cycles", n + 1, 255);
    base8 = 8'h00;

    // Duty levels and extremes, applied only at the next boundary
    wr8(2, 1, 64);
    wr8(0, 1, 0);
    wr8(1, 1, 255);
    wr8(3, 2, 0);
    wr8(4, 0, 99);
    check("pending_not_visible", leds8, 0);
    wait_pt(0, 400, n);
    check("boundary_after_writes", n, 250);
    measure(0, 255);
    check("ch0_duty0_on", on_cnt[0], 0);
    check("ch1_duty255_on", on_cnt[1], 255);
    check("ch2_duty64_on", on_cnt[2], 64);
    check("ch3_on_mode", on_cnt[3], 255);
    check("ch4_off_mode", on_cnt[4], 0);
    check("period_tick_per_period", pt_cnt, 1);
    check("period_tick_at_255", last_pt, 1);

    // Last write in a period wins; a write on the boundary waits one more period
    wr8(5, 1, 200);
    wr8(5, 1, 10);
    repeat (252) @(negedge clk);
    wr8(7, 1, 50);
    check("write_on_boundary", pt8, 1);
    measure(0, 255);
    check("ch5_last_write_wins", on_cnt[5], 10);
    check("ch7_coincident_deferred", on_cnt[7], 0);
    check("ch2_unchanged", on_cnt[2], 64);
    measure(0, 255);
    check("ch7_applied_later", on_cnt[7], 50);
    check("ch5_holds", on_cnt[5], 10);

    // Prescale lowered from 5 to 2 while pre_cnt is 4
    rst4 = 1'b0;
    repeat (4) @(negedge clk);
    prescale4 = 16'd2;
    wait_pt(1, 200, n);
    check("prescale_drop_first_wrap", n, 43);
    wait_pt(1, 200, n);
    check("prescale2_period", n, 45);

    // Reset discards a pending write; first boundary (1+1)*15 cycles later
    prescale4 = 16'd1;
    wr4(0, 2, 0);
    rst4 = 1'b1;
    @(negedge clk);
    check("reset4_leds", leds4, 0);
    rst4 = 1'b0;
    wait_pt(1, 100, n);
    check("reset4_first_boundary", n, 30);

    // Breathe on ch6 plus an out-of-range select
    wr4(6, 3, 13);
    wr4(7, 2, 15);
    wait_pt(1, 100, n);
    check("breathe_boundary", n, 28);
    others = 0;
    for (int p = 0; p < 20; p++) begin
      measure(1, 30);
      check($sformatf("breathe_p%0d", p), on_cnt[6], 2 * exp_duty[p]);
      if (p == 0) check("reset_discarded_pending", on_cnt[0], 0);
      for (int b = 0; b < 6; b++) others += on_cnt[b];
    end
    check("invalid_sel_no_effect", others, 0);
    check("breathe_period_tick", last_pt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
